// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg : shared state encoding, reset vector and ALU branch codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_sequencer_pkg;

  typedef enum logic {
    SEQ     = 1'b0,
    PENDING = 1'b1
  } seq_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] PC_STEP              = 32'd4;

  typedef enum logic [3:0] {
    ALU_BLTZ   = 4'd0,
    ALU_BGEZ   = 4'd1,
    ALU_BLTZAL = 4'd2,
    ALU_BGEZAL = 4'd3,
    ALU_BEQ    = 4'd4,
    ALU_BNE    = 4'd5,
    ALU_BLEZ   = 4'd6,
    ALU_BGTZ   = 4'd7,
    ALU_J      = 4'd8,
    ALU_JAL    = 4'd9,
    ALU_JR     = 4'd10,
    ALU_JALR   = 4'd11
  } alu_bj_op_e;

  function automatic logic bj_is_branch(input alu_bj_op_e op);
    return (op <= ALU_BGTZ);
  endfunction

  function automatic logic bj_is_jump_reg(input alu_bj_op_e op);
    return (op == ALU_JR) || (op == ALU_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc : combinational branch / jump / jump-register target forms
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [25:0] jindex,
  input  logic [31:0] target,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        stall,
  output logic [31:0] pc4,
  output logic [31:0] btgt,
  output logic [31:0] jtgt,
  output logic [31:0] rtgt,
  output logic        misalign
);

  assign pc4      = pc + PC_STEP;
  assign btgt     = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign jtgt     = {pc4[31:28], jindex, 2'b00};
  assign rtgt     = {target[31:2], 2'b00};
  assign misalign = jump & jump_reg & (|target[1:0]) & ~stall;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : PC register with optional MIPS branch-delay-slot sequencing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter bit          DELAY_SLOT   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_in,
  input  logic        Branch_in,
  input  logic        Jump_in,
  input  logic        JumpReg_in,
  input  logic [31:0] Target_in,
  input  logic [15:0] Imm_in,
  input  logic [25:0] JIndex_in,
  output logic [31:0] PC_out,
  output logic [31:0] Link_out,
  output logic        Redirect_out,
  output logic        Misalign_out,
  output logic        SlotViolation_out,
  output logic [31:0] Retired_out
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] w_pc4, w_btgt, w_jtgt, w_rtgt;
  logic [31:0] w_tgt;
  logic        w_take;
  logic        w_pending;

  pc_target_calc u_target_calc (
    .pc       (pc_q),
    .imm      (Imm_in),
    .jindex   (JIndex_in),
    .target   (Target_in),
    .jump     (Jump_in),
    .jump_reg (JumpReg_in),
    .stall    (Stall_in),
    .pc4      (w_pc4),
    .btgt     (w_btgt),
    .jtgt     (w_jtgt),
    .rtgt     (w_rtgt),
    .misalign (Misalign_out)
  );

  assign w_take    = Branch_in | Jump_in;
  assign w_tgt     = Jump_in ? (JumpReg_in ? w_rtgt : w_jtgt) : w_btgt;
  assign w_pending = DELAY_SLOT && (state_q == PENDING);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    retired_d = retired_q;
    if (!Stall_in) begin
      retired_d = retired_q + 32'd1;
      if (DELAY_SLOT) begin
        // A branch/jump in the delay slot is dropped; the earlier redirect wins.
        if (state_q == PENDING) begin
          pc_d    = pend_q;
          state_d = SEQ;
        end else begin
          pc_d = w_pc4;
          if (w_take) begin
            pend_d  = w_tgt;
            state_d = PENDING;
          end
        end
      end else begin
        pc_d = w_take ? w_tgt : w_pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEQ;
      pc_q      <= RESET_VECTOR;
      pend_q    <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      retired_q <= retired_d;
    end
  end

  assign PC_out            = pc_q;
  assign Retired_out       = retired_q;
  assign Link_out          = DELAY_SLOT ? (pc_q + 32'd8) : w_pc4;
  assign Redirect_out      = ~Stall_in & (DELAY_SLOT ? w_pending : w_take);
  assign SlotViolation_out = ~Stall_in & w_pending & w_take;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Scoreboarded random bench for pc_sequencer; one instance with and one without delay slots.
`default_nettype none

module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, stall, br, jp, jr;
  logic [31:0] tin;
  logic [15:0] imm;
  logic [25:0] jidx;

  logic [31:0] pc_o   [2];
  logic [31:0] link_o [2];
  logic [31:0] ret_o  [2];
  logic        redir_o[2];
  logic        mis_o  [2];
  logic        slot_o [2];

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .DELAY_SLOT(1'b1)) dut_ds1 (
    .clk(clk), .reset(reset), .Stall_in(stall), .Branch_in(br), .Jump_in(jp),
    .JumpReg_in(jr), .Target_in(tin), .Imm_in(imm), .JIndex_in(jidx),
    .PC_out(pc_o[0]), .Link_out(link_o[0]), .Redirect_out(redir_o[0]),
    .Misalign_out(mis_o[0]), .SlotViolation_out(slot_o[0]), .Retired_out(ret_o[0]));

  pc_sequencer #(.RESET_VECTOR(RV), .DELAY_SLOT(1'b0)) dut_ds0 (
    .clk(clk), .reset(reset), .Stall_in(stall), .Branch_in(br), .Jump_in(jp),
    .JumpReg_in(jr), .Target_in(tin), .Imm_in(imm), .JIndex_in(jidx),
    .PC_out(pc_o[1]), .Link_out(link_o[1]), .Redirect_out(redir_o[1]),
    .Misalign_out(mis_o[1]), .SlotViolation_out(slot_o[1]), .Retired_out(ret_o[1]));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] link;
    logic [31:0] ret;
    logic        redir;
    logic        mis;
    logic        slot;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: instance 0 has delay slots, instance 1 redirects immediately.
  logic [31:0] m_pc[2];
  logic [31:0] m_ret;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_pc[0] = RV;
    m_pc[1] = RV;
    m_ret   = 32'd0;
    m_pend.delete();
  endtask

  task automatic step(input bit r, input bit s, input bit b, input bit j, input bit jreg,
                      input logic [31:0] t, input logic [15:0] im, input logic [25:0] ji);
    logic [31:0] pc4, btgt, jtgt, rtgt, tgt;
    int          off;
    bit          take;
    exp_t        e;
    @(posedge clk);
    #1;
    reset = r; stall = s; br = b; jp = j; jr = jreg; tin = t; imm = im; jidx = ji;
    take = b || j;
    off  = int'($signed(im));
    for (int k = 0; k < 2; k++) begin
      pc4  = m_pc[k] + 32'd4;
      btgt = pc4 + 32'(off * 4);
      jtgt = (pc4 & 32'hF000_0000) | (32'(ji) * 32'd4);
      rtgt = t & 32'hFFFF_FFFC;
      tgt  = j ? (jreg ? rtgt : jtgt) : btgt;
      e.pc   = m_pc[k];
      e.ret  = m_ret;
      e.mis  = j && jreg && (t % 4 != 0) && !s;
      e.link = (k == 0) ? m_pc[k] + 32'd8 : pc4;
      if (k == 0) begin
        e.redir = !s && (m_pend.size() != 0);
        e.slot  = !s && (m_pend.size() != 0) && take;
        exp_q0.push_back(e);
      end else begin
        e.redir = !s && take;
        e.slot  = 1'b0;
        exp_q1.push_back(e);
      end
      if (!r && !s) begin
        if (k == 0) begin
          if (m_pend.size() != 0) m_pc[0] = m_pend.pop_front();
          else begin
            m_pc[0] = pc4;
            if (take) m_pend.push_back(tgt);
          end
        end else begin
          m_pc[1] = take ? tgt : pc4;
        end
      end
    end
    if (r) model_reset();
    else if (!s) m_ret = m_ret + 32'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[ds%0d] @%0t: got %h expected %h", name, 1 - k, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs, pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q0.size() != 0) begin
      e = exp_q0.pop_front();
      chk("pc", 0, pc_o[0], e.pc);       chk("link", 0, link_o[0], e.link);
      chk("retired", 0, ret_o[0], e.ret); chk("redirect", 0, 32'(redir_o[0]), 32'(e.redir));
      chk("misalign", 0, 32'(mis_o[0]), 32'(e.mis)); chk("slot", 0, 32'(slot_o[0]), 32'(e.slot));
    end
    if (exp_q1.size() != 0) begin
      e = exp_q1.pop_front();
      chk("pc", 1, pc_o[1], e.pc);       chk("link", 1, link_o[1], e.link);
      chk("retired", 1, ret_o[1], e.ret); chk("redirect", 1, 32'(redir_o[1]), 32'(e.redir));
      chk("misalign", 1, 32'(mis_o[1]), 32'(e.mis)); chk("slot", 1, 32'(slot_o[1]), 32'(e.slot));
    end
  end

  initial begin
    alu_bj_op_e op;
    bit         b, j, jreg;
    reset = 1'b1; stall = 1'b0; br = 1'b0; jp = 1'b0; jr = 1'b0;
    tin = '0; imm = '0; jidx = '0;
    @(posedge clk);
    model_reset();

    // Sequential fetch, then backward branch from 0x00400010.
    idle(4);
    step(0, 0, 1, 0, 0, 32'h0, 16'hFFFC, 26'h0);
    idle(3);

    // Misaligned JR from 0x00400020.
    step(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    idle(8);
    step(0, 0, 0, 1, 1, 32'h1000_0023, 16'h0, 26'h0);
    idle(3);

    // Jump in the delay slot is ignored.
    step(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    step(0, 0, 1, 0, 0, 32'h0, 16'h0010, 26'h0);
    step(0, 0, 0, 1, 0, 32'h0, 16'h0, 26'h0000_3FF);
    idle(2);

    // Stall for three cycles while a redirect is pending.
    step(0, 0, 1, 0, 0, 32'h0, 16'h0020, 26'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 32'h0000_0003, 16'h0, 26'h0);
    idle(3);

    // J to index 0x100, then reset while the delay-slot instance is pending.
    step(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    step(0, 0, 0, 1, 0, 32'h0, 16'h0, 26'h000_0100);
    step(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    idle(3);

    // PC wrap past 0xFFFFFFFC.
    step(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 16'h0, 26'h0);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      b = 0; j = 0; jreg = 0;
      if ($urandom_range(0, 3) == 0) begin
        op = alu_bj_op_e'($urandom_range(0, 11));
        if (bj_is_branch(op)) b = $urandom_range(0, 1) != 0;
        else begin
          j    = 1;
          jreg = bj_is_jump_reg(op);
          b    = $urandom_range(0, 7) == 0;
        end
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, b, j, jreg,
           $urandom(), 16'($urandom()), 26'($urandom()));
    end

    for (int i = 0; i < 10 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(posedge clk);
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q0.size() + exp_q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
